mips_hazard_ctrl: RTL

- Parametrised hazard, forwarding and flush controller for the 5-stage MIPS pipeline.
- Replaces the hard-wired "flush IF/ID on PCSrc||Jump" logic.
- Keeps its own shadow scoreboard of the EX/MEM/WB stages and produces:
  - load-use stalls,
  - forwarding selects for both ALU operands,
  - stage flushes sized by a configurable branch-resolution stage,
  - saturating performance counters.
- Sits beside the datapath, driven by IF/ID decode fields and the branch outcome.

---
 rtl/mips_hazard_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/mips_hazard_ctrl.sv
// mips_hazard_ctrl: load-use stall, operand forwarding and flush control for
// the 5-stage MIPS pipeline. It keeps a shadow copy of the EX/MEM/WB stage
// control fields so that it does not depend on the datapath pipeline registers.
// It also maintains saturating stall, flush and retire counters.
module mips_hazard_ctrl #(
    parameter int REG_AW       = 5,
    parameter int BRANCH_STAGE = 2,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_jump,
    input  logic              br_taken,
    output logic              pc_stall,
    output logic              ifid_stall,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              exmem_bubble,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  retire_cnt
);

    // Only EX and MEM are meaningful resolution points for a branch.
    if (BRANCH_STAGE != 2 && BRANCH_STAGE != 3) begin : g_bad_branch_stage
        $error("mips_hazard_ctrl: BRANCH_STAGE must be 2 (EX) or 3 (MEM)");
    end

    localparam bit               LATE_BRANCH = (BRANCH_STAGE == 3);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [1:0]       SEL_RF      = 2'b00;
    localparam logic [1:0]       SEL_WB      = 2'b01;
    localparam logic [1:0]       SEL_MEM     = 2'b10;

    // Shadow EX stage. It also records the source registers so that forwarding
    // can be decided for the instruction currently in EX.
    logic              ex_valid;
    logic [REG_AW-1:0] ex_dst;
    logic              ex_regwrite;
    logic              ex_memread;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic              ex_use_rs;
    logic              ex_use_rt;

    // Shadow MEM and WB stages. The load flag only matters while an
    // instruction is in EX, so it is not carried any further.
    logic              mem_valid;
    logic [REG_AW-1:0] mem_dst;
    logic              mem_regwrite;
    logic              wb_valid;
    logic [REG_AW-1:0] wb_dst;
    logic              wb_regwrite;

    logic mem_eligible;
    logic wb_eligible;
    logic load_use;
    logic branch_flush;
    logic jump_taken;

    assign mem_eligible = mem_valid && mem_regwrite && (mem_dst != '0);
    assign wb_eligible  = wb_valid  && wb_regwrite  && (wb_dst  != '0);

    assign load_use = id_valid && ex_valid && ex_memread && (ex_dst != '0) &&
                      ((id_use_rs && (id_rs == ex_dst)) ||
                       (id_use_rt && (id_rt == ex_dst)));

    assign branch_flush = br_taken && (LATE_BRANCH ? mem_valid : ex_valid);

    // A jump is honoured only when neither a branch flush nor a stall takes
    // priority. A stalled jump is seen again on the next cycle.
    assign jump_taken = id_valid && id_jump && !branch_flush && !load_use;

    // Pipeline control: reset forcing first, then branch > load-use > jump.
    always_comb begin
        pc_stall     = 1'b0;
        ifid_stall   = 1'b0;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        if (!reset) begin
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            exmem_bubble = LATE_BRANCH;
        end else if (branch_flush) begin
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            exmem_bubble = LATE_BRANCH;
        end else if (load_use) begin
            pc_stall     = 1'b1;
            ifid_stall   = 1'b1;
            idex_bubble  = 1'b1;
        end else if (jump_taken) begin
            ifid_flush   = 1'b1;
        end
    end

    // Operand forwarding for the EX instruction. The younger MEM result wins over WB.
    always_comb begin
        fwd_a_sel = SEL_RF;
        fwd_b_sel = SEL_RF;
        if (reset && ex_valid) begin
            if (ex_use_rs && mem_eligible && (mem_dst == ex_rs)) begin
                fwd_a_sel = SEL_MEM;
            end else if (ex_use_rs && wb_eligible && (wb_dst == ex_rs)) begin
                fwd_a_sel = SEL_WB;
            end
            if (ex_use_rt && mem_eligible && (mem_dst == ex_rt)) begin
                fwd_b_sel = SEL_MEM;
            end else if (ex_use_rt && wb_eligible && (wb_dst == ex_rt)) begin
                fwd_b_sel = SEL_WB;
            end
        end
    end

    // Shadow pipeline advance every clock; bubbles invalidate the receiving stage.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_valid     <= 1'b0;
            ex_dst       <= '0;
            ex_regwrite  <= 1'b0;
            ex_memread   <= 1'b0;
            ex_rs        <= '0;
            ex_rt        <= '0;
            ex_use_rs    <= 1'b0;
            ex_use_rt    <= 1'b0;
            mem_valid    <= 1'b0;
            mem_dst      <= '0;
            mem_regwrite <= 1'b0;
            wb_valid     <= 1'b0;
            wb_dst       <= '0;
            wb_regwrite  <= 1'b0;
        end else begin
            ex_valid     <= id_valid && !idex_bubble;
            ex_dst       <= id_dst;
            ex_regwrite  <= id_regwrite;
            ex_memread   <= id_memread;
            ex_rs        <= id_rs;
            ex_rt        <= id_rt;
            ex_use_rs    <= id_use_rs;
            ex_use_rt    <= id_use_rt;
            mem_valid    <= ex_valid && !exmem_bubble;
            mem_dst      <= ex_dst;
            mem_regwrite <= ex_regwrite;
            wb_valid     <= mem_valid;
            wb_dst       <= mem_dst;
            wb_regwrite  <= mem_regwrite;
        end
    end

    // Saturating performance counters. Each counter holds at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            if (load_use && !branch_flush && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if ((branch_flush || jump_taken) && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
            if (wb_valid && (retire_cnt != CNT_MAX)) begin
                retire_cnt <= retire_cnt + CNT_ONE;
            end
        end
    end

endmodule
